alu_multicycle: RTL and testbench

Parametrised successor of the core's single-cycle ALU. It adds carry-in arithmetic (ADC/SBC) and an iterative shift-add multiplier (MUL/MLA) behind a start/ready/done handshake. It sits in the datapath between the SrcA/SrcB muxes and the result mux. The controller stalls PC update while ready=0.

---
 rtl/alu_mc_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 67 ++++++
 rtl/alu_multicycle.sv | 214 +++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - opcodes, FSM states and flag indices shared by alu_multicycle
// Purpose: common definitions for the multicycle ALU and its testbench-independent users.
// Contents: OP_* opcode constants, state_e FSM encoding, FLAG_* bit positions in ALUFlags.
package alu_mc_pkg;

   localparam logic [4:0] OP_ADD   = 5'b00000;
   localparam logic [4:0] OP_SUB   = 5'b00001;
   localparam logic [4:0] OP_AND   = 5'b00010;
   localparam logic [4:0] OP_ORR   = 5'b00011;
   localparam logic [4:0] OP_ADC   = 5'b00100;
   localparam logic [4:0] OP_SBC   = 5'b00101;
   localparam logic [4:0] OP_EOR   = 5'b00110;
   localparam logic [4:0] OP_TST   = 5'b00111;
   localparam logic [4:0] OP_MUL   = 5'b01000;
   localparam logic [4:0] OP_MLA   = 5'b01001;
   localparam logic [4:0] OP_UMULL = 5'b01010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier, MUL_BITS bits per step
// Purpose: computes a_in*b_in over WIDTH/MUL_BITS steps, multiplier bits consumed LSB first.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   load            capture a_in (multiplicand) and b_in (multiplier), clear step counter
//   step            retire the next MUL_BITS multiplier bits
//   a_in, b_in      operands, sampled on load
//   last            high while the final step is being taken
//   product         2*WIDTH-bit product register
module alu_mul_iter #(
   parameter int WIDTH    = 32,
   parameter int MUL_BITS = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               last,
   output logic [2*WIDTH-1:0] product
);

   localparam int ITER  = WIDTH / MUL_BITS;
   localparam int CNT_W = $clog2(ITER + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

   logic [WIDTH-1:0]          mcand_q, mcand_d;
   logic [2*WIDTH-1:0]        prod_q, prod_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [WIDTH+MUL_BITS-1:0] partial;

   // The low half of the product register starts as the multiplier and is
   // shifted out as the accumulated high half grows downward into it.
   // hi + a*digit < 2^(WIDTH+MUL_BITS), so the partial sum never overflows.
   always_comb begin
      mcand_d = mcand_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      partial = {{MUL_BITS{1'b0}}, prod_q[2*WIDTH-1:WIDTH]}
              + ({{MUL_BITS{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, prod_q[MUL_BITS-1:0]});
      if (load) begin
         mcand_d = a_in;
         prod_d  = {{WIDTH{1'b0}}, b_in};
         cnt_d   = '0;
      end else if (step) begin
         prod_d  = {partial, prod_q[WIDTH-1:MUL_BITS]};
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else begin
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
      end
   end

   assign last    = step && (cnt_q == LAST_CNT);
   assign product = prod_q;

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multicycle ALU with carry-in arithmetic and iterative multiply
// Purpose: start/ready/done wrapped ALU; 1-cycle ops finish one edge after accept,
//   multiplies take WIDTH/MUL_BITS+1 edges. Optional UMULL under macro ALU_MULL_EN.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               request, accepted when start & ready
//   ALUControl          opcode, sampled on accept
//   a, b, acc, CarryIn  operands, sampled on accept
//   ready               idle, may accept
//   done                one-cycle completion pulse
//   Result, ResultHi    registered results (ResultHi nonzero only for UMULL)
//   ALUFlags            registered {N,Z,C,V}
module alu_multicycle
   import alu_mc_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_BITS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       ALUControl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc,
   input  logic             CarryIn,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] ResultHi,
   output logic [3:0]       ALUFlags
);

   state_e             state_q, state_d;
   logic [4:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic               cin_q, cin_d;
   logic               fin_q, fin_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [3:0]         flags_q, flags_d;

   logic               mul_load, mul_step, mul_last;
   logic [2*WIDTH-1:0] product;

   logic               inv, cin_eff, ex_known, ex_arith;
   logic [WIDTH-1:0]   b_eff, ex_res, ex_hi;
   logic [WIDTH:0]     sum_ext;
   logic [3:0]         ex_flags;

   function automatic logic is_mul_op(input logic [4:0] op);
`ifdef ALU_MULL_EN
      return (op == OP_MUL) || (op == OP_MLA) || (op == OP_UMULL);
`else
      return (op == OP_MUL) || (op == OP_MLA);
`endif
   endfunction

   alu_mul_iter #(
      .WIDTH    (WIDTH),
      .MUL_BITS (MUL_BITS)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .load    (mul_load),
      .step    (mul_step),
      .a_in    (a),
      .b_in    (b),
      .last    (mul_last),
      .product (product)
   );

   // Result and flags from the registered operands (and finished product).
   always_comb begin
      inv   = (op_q == OP_SUB) || (op_q == OP_SBC);
      b_eff = inv ? ~b_q : b_q;
      case (op_q)
         OP_SUB:         cin_eff = 1'b1;
         OP_ADC, OP_SBC: cin_eff = cin_q;
         default:        cin_eff = 1'b0;
      endcase
      sum_ext  = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
      ex_res   = '0;
      ex_hi    = '0;
      ex_known = 1'b1;
      ex_arith = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
            ex_res   = sum_ext[WIDTH-1:0];
            ex_arith = 1'b1;
         end
         OP_AND, OP_TST: ex_res = a_q & b_q;
         OP_ORR:         ex_res = a_q | b_q;
         OP_EOR:         ex_res = a_q ^ b_q;
         OP_MUL:         ex_res = product[WIDTH-1:0];
         OP_MLA:         ex_res = product[WIDTH-1:0] + acc_q;
`ifdef ALU_MULL_EN
         OP_UMULL: begin
            ex_res = product[WIDTH-1:0];
            ex_hi  = product[2*WIDTH-1:WIDTH];
         end
`endif
         default:        ex_known = 1'b0;
      endcase
      ex_flags = '0;
      if (ex_known) begin
`ifdef ALU_MULL_EN
         ex_flags[FLAG_N] = (op_q == OP_UMULL) ? ex_hi[WIDTH-1] : ex_res[WIDTH-1];
`else
         ex_flags[FLAG_N] = ex_res[WIDTH-1];
`endif
         ex_flags[FLAG_Z] = ({ex_hi, ex_res} == '0);
         ex_flags[FLAG_C] = ex_arith & sum_ext[WIDTH];
         ex_flags[FLAG_V] = ex_arith & ~(a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ inv)
                                     & (a_q[WIDTH-1] ^ sum_ext[WIDTH-1]);
      end
   end

`ifdef ALU_MULL_EN
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
`else
   logic unused_prod_hi;
   assign unused_prod_hi = ^product[2*WIDTH-1:WIDTH];
`endif

   // MUL also serves as the one-cycle execute state for non-multiply ops.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cin_d    = cin_q;
      fin_d    = fin_q;
      result_d = result_q;
      flags_d  = flags_q;
`ifdef ALU_MULL_EN
      result_hi_d = result_hi_q;
`endif
      mul_load = 1'b0;
      mul_step = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d     = ALUControl;
               a_d      = a;
               b_d      = b;
               acc_d    = acc;
               cin_d    = CarryIn;
               fin_d    = 1'b0;
               mul_load = is_mul_op(ALUControl);
               state_d  = MUL;
            end
         end
         MUL: begin
            if (!is_mul_op(op_q) || fin_q) begin
               result_d = ex_res;
               flags_d  = ex_flags;
`ifdef ALU_MULL_EN
               result_hi_d = ex_hi;
`endif
               state_d  = DONE;
            end else begin
               mul_step = 1'b1;
               fin_d    = mul_last;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cin_q    <= 1'b0;
         fin_q    <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cin_q    <= cin_d;
         fin_q    <= fin_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

`ifdef ALU_MULL_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         result_hi_q <= '0;
      end else begin
         result_hi_q <= result_hi_d;
      end
   end
   assign ResultHi = result_hi_q;
`else
   assign ResultHi = '0;
`endif

   assign ready    = (state_q == IDLE);
   assign done     = (state_q == DONE);
   assign Result   = result_q;
   assign ALUFlags = flags_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle (MUL_BITS=1 and MUL_BITS=4)
module tb_alu_multicycle;

   localparam logic [4:0] T_ADD = 5'b00000, T_SUB = 5'b00001, T_AND = 5'b00010,
                          T_ORR = 5'b00011, T_ADC = 5'b00100, T_SBC = 5'b00101,
                          T_EOR = 5'b00110, T_TST = 5'b00111, T_MUL = 5'b01000,
                          T_MLA = 5'b01001, T_UMULL = 5'b01010;
   localparam logic [4:0] OP_TAB [11] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                          5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                          5'b01000, 5'b01001, 5'b01010};
   localparam logic [31:0] CORNER [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                                          32'hFFFF_FFFF, 32'h0000_FFFF};

   logic        clk = 1'b0;
   logic        reset, start, CarryIn;
   logic [4:0]  ALUControl;
   logic [31:0] a, b, acc;
   logic        ready1, done1, ready4, done4;
   logic [31:0] res1, hi1, res4, hi4;
   logic [3:0]  flags1, flags4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(32), .MUL_BITS(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
      .a(a), .b(b), .acc(acc), .CarryIn(CarryIn),
      .ready(ready1), .done(done1), .Result(res1), .ResultHi(hi1), .ALUFlags(flags1));

   alu_multicycle #(.WIDTH(32), .MUL_BITS(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
      .a(a), .b(b), .acc(acc), .CarryIn(CarryIn),
      .ready(ready4), .done(done4), .Result(res4), .ResultHi(hi4), .ALUFlags(flags4));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: arithmetic on 64-bit integers, signed range test for V.
   function automatic void ref_model(input logic [4:0] op, input logic [31:0] x, y, z,
         input logic ci, output logic [31:0] r, output logic [31:0] h,
         output logic [3:0] f, output logic is_mul);
      longint          sx, sy, sfull;
      longint unsigned ux, uy, uz, full;
      logic            c, v, known, umull;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = 64'(x);
      uy = 64'(y);
      uz = 64'(z);
      r = '0; h = '0; c = 1'b0; sfull = 0; known = 1'b1; umull = 1'b0; is_mul = 1'b0;
      case (op)
         T_ADD: begin full = ux + uy; r = full[31:0]; c = (full > 64'hFFFF_FFFF); sfull = sx + sy; end
         T_SUB: begin r = x - y; c = (ux >= uy); sfull = sx - sy; end
         T_ADC: begin full = ux + uy + 64'(ci); r = full[31:0]; c = (full > 64'hFFFF_FFFF);
                      sfull = sx + sy + longint'(ci); end
         T_SBC: begin r = x - y - 32'(!ci); c = (ux >= uy + 64'(!ci)); sfull = sx - sy - longint'(!ci); end
         T_AND, T_TST: r = x & y;
         T_ORR: r = x | y;
         T_EOR: r = x ^ y;
         T_MUL: begin full = ux * uy; r = full[31:0]; is_mul = 1'b1; end
         T_MLA: begin full = ux * uy + uz; r = full[31:0]; is_mul = 1'b1; end
`ifdef ALU_MULL_EN
         T_UMULL: begin full = ux * uy; r = full[31:0]; h = full[63:32]; umull = 1'b1; is_mul = 1'b1; end
`endif
         default: known = 1'b0;
      endcase
      v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
      f = known ? {umull ? h[31] : r[31], (r == 0) && (h == 0), c, v} : 4'b0000;
   endfunction

   // Caller sits just after a negedge with both DUTs idle.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] x, y, z,
         input logic ci);
      logic [31:0] er, eh, r1, h1, r4, h4;
      logic [3:0]  ef, f1, f4;
      logic        em;
      int          lat1, lat4, nd1, nd4, win, inj;
      ref_model(op, x, y, z, ci, er, eh, ef, em);
      r1 = '0; h1 = '0; r4 = '0; h4 = '0; f1 = '0; f4 = '0;
      ALUControl = op; a = x; b = y; acc = z; CarryIn = ci; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat1 = -1; lat4 = -1; nd1 = 0; nd4 = 0;
      win = em ? 36 : 4;
      inj = em ? 3 : 1;
      for (int i = 1; i <= win; i++) begin
         @(negedge clk);
         if (done1) begin
            nd1++;
            if (lat1 < 0) begin lat1 = i; r1 = res1; h1 = hi1; f1 = flags1; end
         end
         if (done4) begin
            nd4++;
            if (lat4 < 0) begin lat4 = i; r4 = res4; h4 = hi4; f4 = flags4; end
         end
         start = 1'b0;
         if (i == inj) begin
            // Busy-time start: must be ignored by both units.
            ALUControl = T_ADD; a = $urandom; b = $urandom; start = 1'b1;
         end
      end
      check($sformatf("%s lat1", tag), 64'(lat1), em ? 64'd33 : 64'd1);
      check($sformatf("%s lat4", tag), 64'(lat4), em ? 64'd9 : 64'd1);
      check($sformatf("%s ndone1", tag), 64'(nd1), 64'd1);
      check($sformatf("%s ndone4", tag), 64'(nd4), 64'd1);
      check($sformatf("%s res1", tag), {h1, r1}, {eh, er});
      check($sformatf("%s res4", tag), {h4, r4}, {eh, er});
      check($sformatf("%s flags1", tag), 64'(f1), 64'(ef));
      check($sformatf("%s flags4", tag), 64'(f4), 64'(ef));
   endtask

   initial begin
      logic [4:0]  rop;
      logic [31:0] rx, ry, rz;
      int          nd;
      reset = 1'b1; start = 1'b0; ALUControl = '0; a = '0; b = '0; acc = '0; CarryIn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst ready1", 64'(ready1), 64'd1);
      check("rst done1", 64'(done1), 64'd0);
      check("rst out1", {hi1, res1, 28'd0, flags1}, 96'd0);
      check("rst ready4", 64'(ready4), 64'd1);
      check("rst out4", {hi4, res4, 28'd0, flags4}, 96'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op("add_ovf", T_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0);
      run_op("sub_eq", T_SUB, 32'd5, 32'd5, 32'h0, 1'b0);
      run_op("sbc_eq", T_SBC, 32'd5, 32'd5, 32'h0, 1'b0);
      run_op("mul_7x6", T_MUL, 32'd7, 32'd6, 32'h0, 1'b0);
      run_op("mla_wrap", T_MLA, 32'hFFFF_FFFF, 32'd2, 32'd3, 1'b0);
      run_op("umull_max", T_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
      run_op("unknown", 5'b11111, 32'h1234_5678, 32'h9, 32'h0, 1'b1);
      run_op("adc_c", T_ADC, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);
      run_op("tst_z", T_TST, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         rop = ($urandom_range(0, 4) == 0) ? 5'($urandom) : OP_TAB[$urandom_range(0, 10)];
         rx = ($urandom_range(0, 2) == 0) ? CORNER[$urandom_range(0, 5)] : $urandom;
         ry = ($urandom_range(0, 2) == 0) ? CORNER[$urandom_range(0, 5)] : $urandom;
         rz = $urandom;
         run_op($sformatf("rnd%0d_op%0d", n, rop), rop, rx, ry, rz, 1'($urandom));
      end

      // Abort a multiply with reset; result must not be delivered.
      run_op("pre_rst", T_ADD, 32'h10, 32'h20, 32'h0, 1'b0);
      ALUControl = T_MUL; a = 32'd7; b = 32'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort ready1", 64'(ready1), 64'd1);
      check("abort ready4", 64'(ready4), 64'd1);
      check("abort done", {62'd0, done1, done4}, 64'd0);
      check("abort out1", {hi1, res1, 28'd0, flags1}, 96'd0);
      check("abort out4", {hi4, res4, 28'd0, flags4}, 96'd0);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done1 || done4) nd++;
      end
      check("abort no_done", 64'(nd), 64'd0);
      run_op("post_rst", T_ADD, 32'd1, 32'd2, 32'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
